// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_pkg
//  Description : Shared state encoding and sizing helper for the reset
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [STATE_W-1:0] ST_HOLD      = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_HOLD      = ST_HOLD,
        S_RELEASE   = ST_RELEASE,
        S_RUN       = ST_RUN
    } seq_state_e;

    // Bits needed to index VALUE items; never less than one so that a
    // single-channel build still gets a legal vector.
    function automatic int idx_width(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sync
//  Description : Asynchronous-assert, synchronous-deassert reset bridge.
//                The output drops as soon as rst_n drops and rises
//                SYNC_STAGES clock edges after rst_n rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift a constant one into the chain once the board reset is gone.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Chain clears immediately on rst_n, fills one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sequencer
//  Description : Holds NUM_CH reset outputs asserted for HOLD_CYCLES after
//                clock lock, then releases them one by one STAGGER_CYCLES
//                apart. Re-sequences on software request, re-asserts all
//                channels on loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int                NUM_CH         = 3,
    parameter int                CNT_W          = 10,
    parameter int                HOLD_CYCLES    = 100,
    parameter int                STAGGER_CYCLES = 16,
    parameter int                SYNC_STAGES    = 2,
    parameter logic [NUM_CH-1:0] OUT_POL        = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lock,
    input  logic               sw_rst_req,
    output logic [NUM_CH-1:0]  rst_out,
    output logic               seq_done,
    output logic [STATE_W-1:0] state_o
);

    localparam int                CH_W      = idx_width(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STG_LAST  =
        CNT_W'((STAGGER_CYCLES > 0) ? (STAGGER_CYCLES - 1) : 0);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    // No stagger (or nothing to stagger) means every channel goes at once.
    localparam bit                REL_ALL   = (STAGGER_CYCLES == 0) || (NUM_CH == 1);

    logic                   rst_int_n;
    logic                   lock_s;
    logic [SYNC_STAGES-1:0] lock_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q;

    seq_state_e             state_d,    state_q;
    logic [CNT_W-1:0]       hold_cnt_d, hold_cnt_q;
    logic [CNT_W-1:0]       stg_cnt_d,  stg_cnt_q;
    logic [CH_W-1:0]        ch_idx_d,   ch_idx_q;
    logic [CH_W-1:0]        ch_nxt;
    logic [NUM_CH-1:0]      asserted_d, asserted_q;
    logic [NUM_CH-1:0]      rst_out_d,  rst_out_q;
    logic                   seq_done_d, seq_done_q;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_int_n)
    );

    // Lock synchroniser: shift the raw lock level toward lock_s.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], lock};
    end

    // Lock synchroniser flops, held clear while the internal reset is active.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Next-state logic: lock loss beats software restart beats progression.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        ch_idx_d   = ch_idx_q;
        asserted_d = asserted_q;
        seq_done_d = seq_done_q;
        ch_nxt     = ch_idx_q + CH_ONE;

        if ((state_q != S_WAIT_LOCK) && !lock_s) begin
            state_d    = S_WAIT_LOCK;
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            ch_idx_d   = '0;
            asserted_d = '1;
            seq_done_d = 1'b0;
        end else if ((state_q != S_WAIT_LOCK) && sw_rst_req) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            ch_idx_d   = '0;
            asserted_d = '1;
            seq_done_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        stg_cnt_d  = '0;
                        ch_idx_d   = '0;
                        if (REL_ALL) begin
                            asserted_d = '0;
                            seq_done_d = 1'b1;
                            state_d    = S_RUN;
                        end else begin
                            // Channel 0 goes on the same edge RELEASE is entered.
                            asserted_d[0] = 1'b0;
                            state_d       = S_RELEASE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d = '0;
                        ch_idx_d  = ch_nxt;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_nxt == CH_W'(k)) begin
                                asserted_d[k] = 1'b0;
                            end
                        end
                        if (ch_nxt == LAST_CH) begin
                            state_d    = S_RUN;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + CNT_ONE;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                end
            endcase
        end

        // Map the active-high asserted flag onto each channel's polarity.
        rst_out_d = ~(asserted_d ^ OUT_POL);
    end

    // State and output registers, cleared straight away by the internal reset.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= S_WAIT_LOCK;
            hold_cnt_q <= '0;
            stg_cnt_q  <= '0;
            ch_idx_q   <= '0;
            asserted_q <= '1;
            rst_out_q  <= OUT_POL;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            ch_idx_q   <= ch_idx_d;
            asserted_q <= asserted_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;
    assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_sequencer
//  Description : Self-checking bench for rst_sequencer. Three builds share
//                one stimulus: defaults, mixed polarity, and zero stagger
//                with a one-cycle hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rst_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       sw_rst_req;

    logic [N-1:0] rst_out_a, rst_out_b, rst_out_c;
    logic         done_a, done_b, done_c;
    logic [1:0]   state_a, state_b, state_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rst_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .lock(lock), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out_a), .seq_done(done_a), .state_o(state_a)
    );

    rst_sequencer #(.OUT_POL(3'b101)) dut_b (
        .clk(clk), .rst_n(rst_n), .lock(lock), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out_b), .seq_done(done_b), .state_o(state_b)
    );

    rst_sequencer #(.HOLD_CYCLES(1), .STAGGER_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .lock(lock), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out_c), .seq_done(done_c), .state_o(state_c)
    );

    // ---------------- reference model ----------------
    // Sequencer viewed as "inactive" or "t cycles since the sequence (re)started".
    int m_sync_cnt;
    bit m_lock_h [SYNC];
    bit m_active;
    int m_t;

    task automatic model_async_reset();
        m_sync_cnt = 0;
        m_active   = 1'b0;
        m_t        = 0;
        for (int i = 0; i < SYNC; i++) m_lock_h[i] = 1'b0;
    endtask

    task automatic model_step();
        bit irn;
        bit lk;
        if (!rst_n) begin
            model_async_reset();
            return;
        end
        irn = (m_sync_cnt >= SYNC);
        lk  = m_lock_h[SYNC-1];
        if (irn) begin
            if (m_active && !lk) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (m_active && sw_rst_req) begin
                m_t = 0;
            end else if (!m_active && lk) begin
                m_active = 1'b1;
                m_t      = 0;
            end else if (m_active && m_t < 1000000) begin
                m_t = m_t + 1;
            end
            for (int i = SYNC-1; i > 0; i--) m_lock_h[i] = m_lock_h[i-1];
            m_lock_h[0] = lock;
        end
        if (m_sync_cnt < SYNC) m_sync_cnt = m_sync_cnt + 1;
    endtask

    task automatic expect_for(input int hold, input int stag, input logic [N-1:0] pol,
                              output logic [N-1:0] r, output logic d, output logic [1:0] s);
        for (int k = 0; k < N; k++) begin
            if (!m_active || (m_t < hold + k*stag)) r[k] = pol[k];
            else                                    r[k] = !pol[k];
        end
        d = m_active && (m_t >= hold + (N-1)*stag);
        if (!m_active)       s = 2'd0;
        else if (m_t < hold) s = 2'd1;
        else if (d)          s = 2'd3;
        else                 s = 2'd2;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] r;
        logic d;
        logic [1:0] s;
        expect_for(100, 16, 3'b111, r, d, s);
        check("model_a", {10'd0, state_a, done_a, rst_out_a}, {10'd0, s, d, r});
        expect_for(100, 16, 3'b101, r, d, s);
        check("model_b", {10'd0, state_b, done_b, rst_out_b}, {10'd0, s, d, r});
        expect_for(1, 0, 3'b111, r, d, s);
        check("model_c", {10'd0, state_c, done_c, rst_out_c}, {10'd0, s, d, r});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_rst(input logic v);
        if (rst_n && !v) begin
            rst_n = 1'b0;
            model_async_reset();
        end else begin
            rst_n = v;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst_n;
        logic       lock;
        logic       sw;
        int         ncyc;
        logic [1:0] st;
        logic       dn;
        logic [2:0] ra;
        logic [2:0] rb;
    } vec_t;

    vec_t vecs [$];

    initial begin
        rst_n      = 1'b1;
        lock       = 1'b1;
        sw_rst_req = 1'b0;
        model_async_reset();
        #2;
        set_rst(1'b0);

        // reset, sync window, HOLD entry, staggered release
        vecs.push_back('{1'b0, 1'b1, 1'b0,   3, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   4, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  99, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd2, 1'b0, 3'b110, 3'b100});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  15, 2'd2, 1'b0, 3'b110, 3'b100});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd2, 1'b0, 3'b100, 3'b110});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  15, 2'd2, 1'b0, 3'b100, 3'b110});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd3, 1'b1, 3'b000, 3'b010});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   5, 2'd3, 1'b1, 3'b000, 3'b010});
        // software restart from RUN
        vecs.push_back('{1'b1, 1'b1, 1'b1,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 100, 2'd2, 1'b0, 3'b110, 3'b100});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  32, 2'd3, 1'b1, 3'b000, 3'b010});
        // lock lost at T+120, then regained
        vecs.push_back('{1'b1, 1'b1, 1'b1,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 120, 2'd2, 1'b0, 3'b100, 3'b110});
        vecs.push_back('{1'b1, 1'b0, 1'b0,   2, 2'd2, 1'b0, 3'b100, 3'b110});
        vecs.push_back('{1'b1, 1'b0, 1'b0,   1, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   2, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 100, 2'd2, 1'b0, 3'b110, 3'b100});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  16, 2'd2, 1'b0, 3'b100, 3'b110});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  16, 2'd3, 1'b1, 3'b000, 3'b010});
        // software restart in the middle of HOLD
        vecs.push_back('{1'b1, 1'b1, 1'b1,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  50, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b1,   1, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,  99, 2'd1, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd2, 1'b0, 3'b110, 3'b100});
        // lock loss together with sw request, then sw ignored in WAIT_LOCK
        vecs.push_back('{1'b1, 1'b0, 1'b0,   2, 2'd2, 1'b0, 3'b110, 3'b100});
        vecs.push_back('{1'b1, 1'b0, 1'b1,   1, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b0, 1'b1,   3, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   2, 2'd0, 1'b0, 3'b111, 3'b101});
        vecs.push_back('{1'b1, 1'b1, 1'b0,   1, 2'd1, 1'b0, 3'b111, 3'b101});

        for (int i = 0; i < vecs.size(); i++) begin
            set_rst(vecs[i].rst_n);
            lock       = vecs[i].lock;
            sw_rst_req = vecs[i].sw;
            repeat (vecs[i].ncyc) tick();
            check($sformatf("vec%0d", i),
                  {7'd0, state_a, done_a, rst_out_a, rst_out_b},
                  {7'd0, vecs[i].st, vecs[i].dn, vecs[i].ra, vecs[i].rb});
        end

        // asynchronous board reset in the middle of RELEASE
        repeat (110) tick();
        check("pre_async", {13'd0, state_a}, 16'd2);
        #3;
        set_rst(1'b0);
        #1;
        check("async_a", {7'd0, state_a, done_a, rst_out_a, rst_out_b},
                         {7'd0, 2'd0, 1'b0, 3'b111, 3'b101});
        check("async_c", {10'd0, state_c, done_c, rst_out_c},
                         {10'd0, 2'd0, 1'b0, 3'b111});
        tick();
        tick();
        set_rst(1'b1);
        for (int i = 0; i < SYNC; i++) begin
            tick();
            check("sync_hold", {13'd0, rst_out_a}, 16'h0007);
        end
        // zero stagger, one-cycle hold: everything changes together at T+1
        tick();
        tick();
        tick();
        check("c_hold", {10'd0, state_c, done_c, rst_out_c}, {10'd0, 2'd1, 1'b0, 3'b111});
        tick();
        check("c_run",  {10'd0, state_c, done_c, rst_out_c}, {10'd0, 2'd3, 1'b1, 3'b000});

        // randomized segments against the model
        for (int seg = 0; seg < 30; seg++) begin
            int len;
            len = $urandom_range(20, 250);
            set_rst($urandom_range(0, 9) != 0);
            lock = ($urandom_range(0, 4) != 0);
            for (int c = 0; c < len; c++) begin
                sw_rst_req = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 199) == 0) lock = !lock;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
